// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared widths, forward-select codes, md states and shadow-stage type for the pipeline controller
package pipe_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;
  typedef struct packed {
    logic [REG_W-1:0] tag;
    logic wr;
    logic load;
  } stage_t;
  function automatic logic hit(input stage_t s, input logic [REG_W-1:0] src, input logic en);
    return en & s.wr & (s.tag == src) & (src != '0);
  endfunction
endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: mul/div occupancy FSM, busy for MD_LAT cycles after each accepted start
import pipe_ctrl_pkg::*;
module md_busy_counter #(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);
  localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
  md_state_t state;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      state <= MD_IDLE;
      cnt <= '0;
    end else if (state == MD_IDLE) begin
      if (start) begin
        state <= MD_BUSY;
        cnt <= CW'(MD_LAT - 1);
      end
    end else begin
      cnt <= cnt - 1'b1;
      if (cnt == '0) state <= MD_IDLE;
    end
  assign busy = (state == MD_BUSY);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush/forwarding control; forwarding paths exist only when PIPE_FWD_EN is defined
import pipe_ctrl_pkg::*;
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             id_md_start,
  input  logic             id_md_read,
  input  logic             ex_br_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             md_busy
);
  stage_t ex, mem, wb;
  logic hit_ex, load_stall, md_stall, raw_stall, stall, md_go;
  always_comb begin
    hit_ex = hit(ex, id_rs, id_use_rs) | hit(ex, id_rt, id_use_rt);
    load_stall = id_valid & ex.load & hit_ex;
    md_stall = id_valid & md_busy & (id_md_read | id_md_start);
`ifdef PIPE_FWD_EN
    raw_stall = 1'b0;
    fwd_a = hit(mem, id_rs, 1'b1) ? FWD_MEM : hit(wb, id_rs, 1'b1) ? FWD_WB : FWD_RF;
    fwd_b = hit(mem, id_rt, 1'b1) ? FWD_MEM : hit(wb, id_rt, 1'b1) ? FWD_WB : FWD_RF;
`else
    raw_stall = id_valid & (hit_ex | hit(mem, id_rs, id_use_rs) | hit(mem, id_rt, id_use_rt)
                | hit(wb, id_rs, id_use_rs) | hit(wb, id_rt, id_use_rt));
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
`endif
    stall = load_stall | md_stall | raw_stall;
    pc_en = ex_br_taken | ~stall;
    ifid_en = ex_br_taken | ~stall;
    ifid_clr = ex_br_taken;
    idex_bubble = ex_br_taken | stall;
    md_go = id_md_start & id_valid & ~stall & ~ex_br_taken;
  end
  always_ff @(posedge Clk)
    if (Rst) begin
      ex <= '0;
      mem <= '0;
      wb <= '0;
    end else begin
      ex <= '{tag: id_rd, wr: id_wr & id_valid & ~idex_bubble, load: id_load & ~idex_bubble};
      mem <= ex;
      wb <= mem;
    end
  md_busy_counter #(.MD_LAT(MD_LAT)) u_md (
    .clk(Clk),
    .rst(Rst),
    .start(md_go),
    .busy(md_busy)
  );
endmodule
